// File: rtl/bridge_timer.sv
// bridge_timer: processor-bus bridge hosting a countdown timer, a 32-bit output
// port and a 32-bit input port, and forwarding external IRQs onto HWInt[7:3].
// Reads are combinational from PrAddr; writes land on the rising clk edge with PrWe=1.
// Ports: clk/reset (async, active-high); PrAddr/PrWD/PrWe/PrRD bus;
//        HWInt[7:2] interrupt vector; ExtIrq external levels; dev_in/dev_out IO ports.
module bridge_timer #(
  parameter logic [31:0] TIMER_BASE = 32'h0000_7F00,
  parameter logic [31:0] IO_BASE    = 32'h0000_7F10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] PrAddr,
  input  logic [31:0] PrWD,
  input  logic        PrWe,
  output logic [31:0] PrRD,
  output logic [7:2]  HWInt,
  input  logic [4:0]  ExtIrq,
  input  logic [31:0] dev_in,
  output logic [31:0] dev_out
);

  localparam logic [31:0] CTRL_ADDR   = TIMER_BASE;
  localparam logic [31:0] PRESET_ADDR = TIMER_BASE + 32'd4;
  localparam logic [31:0] COUNT_ADDR  = TIMER_BASE + 32'd8;
  localparam logic [31:0] OUT_ADDR    = IO_BASE;
  localparam logic [31:0] IN_ADDR     = IO_BASE + 32'd4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_CNT  = 2'd2,
    S_INT  = 2'd3
  } state_t;

  state_t      state, state_nxt;
  logic [3:0]  ctrl, ctrl_nxt;
  logic [31:0] preset;
  logic [31:0] count, count_nxt;
  logic [31:0] out_reg;
  logic        irq_flag, irq_nxt;

  // Word access only: byte-lane bits are dropped before a full 32-bit decode.
  logic [31:0] word_addr;
  logic        unused_addr_bits;
  assign word_addr        = {PrAddr[31:2], 2'b00};
  assign unused_addr_bits = ^PrAddr[1:0];

  logic wr_ctrl, wr_preset, wr_out;
  assign wr_ctrl   = PrWe && (word_addr == CTRL_ADDR);
  assign wr_preset = PrWe && (word_addr == PRESET_ADDR);
  assign wr_out    = PrWe && (word_addr == OUT_ADDR);

  logic en, auto_reload, im;
  assign en          = ctrl[0];
  assign auto_reload = (ctrl[2:1] == 2'b01);  // 1x decodes as one-shot
  assign im          = ctrl[3];

  // Timer FSM next-state, followed by bus-write overrides so a CTRL write
  // always wins over whatever the FSM would have done on the same edge.
  always_comb begin
    state_nxt = state;
    ctrl_nxt  = ctrl;
    count_nxt = count;
    irq_nxt   = irq_flag;

    case (state)
      S_IDLE: begin
        if (en) state_nxt = S_LOAD;
      end
      S_LOAD: begin
        count_nxt = preset;
        state_nxt = S_CNT;
      end
      S_CNT: begin
        if (!en) begin
          state_nxt = S_IDLE;
        end else if (count == 32'd0) begin
          state_nxt = S_INT;
          irq_nxt   = 1'b1;
        end else begin
          count_nxt = count - 32'd1;
        end
      end
      S_INT: begin
        if (auto_reload) begin
          state_nxt = S_LOAD;
          irq_nxt   = 1'b0;   // flag lives only for the INT cycle: one-cycle pulse
        end else begin
          ctrl_nxt[0] = 1'b0;
          state_nxt   = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase

    if (wr_ctrl) begin
      ctrl_nxt = PrWD[3:0];
      irq_nxt  = 1'b0;
      // Written EN=0 stops the timer this edge: no expiry, count frozen.
      if (!PrWD[0]) begin
        state_nxt = S_IDLE;
        count_nxt = count;
      end
    end
    if (wr_preset) irq_nxt = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      ctrl     <= 4'd0;
      preset   <= 32'd0;
      count    <= 32'd0;
      out_reg  <= 32'd0;
      irq_flag <= 1'b0;
    end else begin
      state    <= state_nxt;
      ctrl     <= ctrl_nxt;
      count    <= count_nxt;
      irq_flag <= irq_nxt;
      if (wr_preset) preset  <= PrWD;
      if (wr_out)    out_reg <= PrWD;
    end
  end

  always_comb begin
    PrRD = 32'd0;
    case (word_addr)
      CTRL_ADDR:   PrRD = {28'd0, ctrl};
      PRESET_ADDR: PrRD = preset;
      COUNT_ADDR:  PrRD = count;
      OUT_ADDR:    PrRD = out_reg;
      IN_ADDR:     PrRD = dev_in;
      default:     PrRD = 32'd0;
    endcase
  end

  assign HWInt   = {ExtIrq, irq_flag & im};
  assign dev_out = out_reg;

endmodule

// File: tb/tb_bridge_timer.sv
// Self-checking bench for bridge_timer: register table plus timer corner sequences.
module tb_bridge_timer;

  localparam logic [31:0] A_CTRL   = 32'h7F00;
  localparam logic [31:0] A_PRESET = 32'h7F04;
  localparam logic [31:0] A_COUNT  = 32'h7F08;
  localparam logic [31:0] A_OUT    = 32'h7F10;
  localparam logic [31:0] A_IN     = 32'h7F14;
  localparam logic [31:0] DEV_IN_V = 32'hA5A5_A5A5;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] PrAddr, PrWD, PrRD;
  logic        PrWe;
  logic [7:2]  HWInt;
  logic [4:0]  ExtIrq;
  logic [31:0] dev_in, dev_out;

  bridge_timer dut (
    .clk(clk), .reset(reset), .PrAddr(PrAddr), .PrWD(PrWD), .PrWe(PrWe),
    .PrRD(PrRD), .HWInt(HWInt), .ExtIrq(ExtIrq), .dev_in(dev_in), .dev_out(dev_out)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] exp_q[$];

  // Scoreboard: expectation is queued at stimulus time and popped when the
  // DUT output is sampled.
  task automatic push_exp(input logic [31:0] v);
    exp_q.push_back(v);
  endtask

  task automatic pop_chk(input string name, input logic [31:0] act);
    logic [31:0] e;
    n_checks++;
    if (exp_q.size() == 0) begin
      $display("FAIL %s: got %h, scoreboard empty", name, act);
      return;
    end
    e = exp_q.pop_front();
    if (act === e) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Write lands on the next rising edge; returns 1 time unit after it.
  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    PrAddr = a; PrWD = d; PrWe = 1'b1;
    @(posedge clk);
    #1;
    PrWe = 1'b0; PrWD = 32'd0;
  endtask

  task automatic read_chk(input string name, input logic [31:0] a, input logic [31:0] e);
    PrAddr = a;
    push_exp(e);
    #1;
    pop_chk(name, PrRD);
  endtask

  task automatic irq_chk(input string name, input logic e);
    push_exp({31'd0, e});
    pop_chk(name, {31'd0, HWInt[2]});
  endtask

  typedef struct {
    logic        we;
    logic [31:0] wr_addr;
    logic [31:0] wd;
    logic [31:0] rd_addr;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[14];

  initial begin
    tbl[0]  = '{1'b0, 32'h0,        32'h0,        A_CTRL,        32'h0};
    tbl[1]  = '{1'b0, 32'h0,        32'h0,        A_PRESET,      32'h0};
    tbl[2]  = '{1'b0, 32'h0,        32'h0,        A_COUNT,       32'h0};
    tbl[3]  = '{1'b0, 32'h0,        32'h0,        A_OUT,         32'h0};
    tbl[4]  = '{1'b0, 32'h0,        32'h0,        A_IN,          DEV_IN_V};
    tbl[5]  = '{1'b0, 32'h0,        32'h0,        32'h7F20,      32'h0};
    tbl[6]  = '{1'b0, 32'h0,        32'h0,        32'h7F0C,      32'h0};
    tbl[7]  = '{1'b1, A_OUT,        32'h12345678, A_OUT,         32'h12345678};
    tbl[8]  = '{1'b1, A_COUNT,      32'h0000FFFF, A_COUNT,       32'h0};
    tbl[9]  = '{1'b1, A_IN,         32'hFFFFFFFF, A_IN,          DEV_IN_V};
    tbl[10] = '{1'b1, A_CTRL,       32'hFFFFFFF6, 32'h7F03,      32'h6};
    tbl[11] = '{1'b1, A_PRESET,     32'hDEADBEEF, 32'h7F05,      32'hDEADBEEF};
    tbl[12] = '{1'b1, 32'h00017F10, 32'h1,        A_OUT,         32'h12345678};
    tbl[13] = '{1'b1, A_CTRL,       32'h0,        32'h00017F00,  32'h0};

    reset = 1'b1; PrAddr = 32'h0; PrWD = 32'h0; PrWe = 1'b0;
    ExtIrq = 5'd0; dev_in = DEV_IN_V;
    tick(2);
    @(negedge clk);
    reset = 1'b0;
    tick(1);

    // Reset state and register map
    push_exp(32'h0); pop_chk("reset_hwint", {26'd0, HWInt});
    push_exp(32'h0); pop_chk("reset_dev_out", dev_out);
    for (int i = 0; i < 14; i++) begin
      if (tbl[i].we) bus_write(tbl[i].wr_addr, tbl[i].wd);
      read_chk($sformatf("tbl_%0d", i), tbl[i].rd_addr, tbl[i].exp);
    end
    push_exp(32'h12345678); pop_chk("dev_out", dev_out);
    read_chk("ctrl_after_0x7F00", A_CTRL, 32'h0);

    // ExtIrq passthrough is combinational
    ExtIrq = 5'b10101;
    #1;
    push_exp(32'h15); pop_chk("extirq", {27'd0, HWInt[7:3]});
    ExtIrq = 5'b01010;
    #1;
    push_exp(32'h0A); pop_chk("extirq2", {27'd0, HWInt[7:3]});
    ExtIrq = 5'd0;

    // One-shot, IM=1, PRESET=3
    bus_write(A_PRESET, 32'd3);
    bus_write(A_CTRL, 32'h9);           // edge 0
    tick(2);
    read_chk("os_cnt3", A_COUNT, 32'd3);
    tick(1); read_chk("os_cnt2", A_COUNT, 32'd2);
    tick(1); read_chk("os_cnt1", A_COUNT, 32'd1);
    tick(1); read_chk("os_cnt0", A_COUNT, 32'd0);
    irq_chk("os_irq_e5", 1'b0);
    tick(1); irq_chk("os_irq_e6", 1'b1);
    tick(1); read_chk("os_ctrl", A_CTRL, 32'h8);
    irq_chk("os_irq_e7", 1'b1);
    tick(3); irq_chk("os_irq_hold", 1'b1);
    bus_write(A_CTRL, 32'h8);
    irq_chk("os_irq_clr", 1'b0);

    // Auto-reload PRESET=2: pulse after edges 5,10,15,20
    bus_write(A_PRESET, 32'd2);
    bus_write(A_CTRL, 32'hB);
    for (int k = 1; k <= 21; k++) begin
      tick(1);
      irq_chk($sformatf("ar_e%0d", k), (k >= 5) && ((k - 5) % 5 == 0));
    end
    read_chk("ar_ctrl", A_CTRL, 32'hB);
    bus_write(A_CTRL, 32'h0);

    // IM=0: expiry invisible, later CTRL write clears the flag
    bus_write(A_PRESET, 32'd5);
    bus_write(A_CTRL, 32'h1);
    tick(8);
    irq_chk("masked_e8", 1'b0);
    read_chk("masked_cnt", A_COUNT, 32'd0);
    tick(1);
    read_chk("masked_ctrl_en_clr", A_CTRL, 32'h0);
    bus_write(A_CTRL, 32'h8);
    irq_chk("masked_unmask", 1'b0);
    tick(3); irq_chk("masked_unmask_hold", 1'b0);

    // EN=0 written on the edge where CNT sees COUNT==0
    bus_write(A_PRESET, 32'd2);
    bus_write(A_CTRL, 32'h9);
    tick(4);
    read_chk("race_cnt0", A_COUNT, 32'd0);
    bus_write(A_CTRL, 32'h8);
    irq_chk("race_irq", 1'b0);
    read_chk("race_ctrl", A_CTRL, 32'h8);
    for (int k = 0; k < 4; k++) begin
      tick(1);
      irq_chk($sformatf("race_irq_%0d", k), 1'b0);
    end

    // Reset mid-count takes effect without a clock edge
    bus_write(A_OUT, 32'hCAFE0001);
    bus_write(A_PRESET, 32'd10);
    bus_write(A_CTRL, 32'h1);
    tick(4);
    read_chk("pre_rst_cnt", A_COUNT, 32'd8);
    PrAddr = A_COUNT;
    #1;
    reset = 1'b1;
    #1;
    push_exp(32'h0); pop_chk("rst_cnt", PrRD);
    read_chk("rst_ctrl", A_CTRL, 32'h0);
    read_chk("rst_preset", A_PRESET, 32'h0);
    push_exp(32'h0); pop_chk("rst_dev_out", dev_out);
    @(negedge clk);
    reset = 1'b0;
    tick(3);
    read_chk("post_rst_cnt", A_COUNT, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
